// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external ALU between two valid/ready requesters.
// Captures one operation, issues it for a single EXEC cycle, and returns a registered result.
module alu_arbiter #(
    parameter int WIDTH = 32  // the attached ALU is 32-bit; no other width is meaningful
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [3:0]       i_req0_op,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,

    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [3:0]       i_req1_op,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,

    output logic             o_rsp0_valid,
    input  logic             i_rsp0_ready,
    output logic [WIDTH-1:0] o_rsp0_data,
    output logic             o_rsp0_zero,
    output logic             o_rsp0_err,

    output logic             o_rsp1_valid,
    input  logic             i_rsp1_ready,
    output logic [WIDTH-1:0] o_rsp1_data,
    output logic             o_rsp1_zero,
    output logic             o_rsp1_err,

    output logic [3:0]       o_alu_op,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic             i_alu_zero
);

    // state | meaning
    // IDLE  | arbitrate and accept one request
    // EXEC  | drive ALU from latched operands, capture result
    // RESP  | present result to owner until it is taken
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_prio;
    logic             r_owner;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_err;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_rsp_done;
    logic             w_rsp_ready;
    logic [3:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_sel_undef;

    // Undefined encodings are exactly 1x1x: 1010, 1011, 1110, 1111.
    function automatic logic op_undefined(input logic [3:0] op);
        return op[3] & op[1];
    endfunction

    assign w_grant0    = i_req0_valid && (!i_req1_valid || !r_prio);
    assign w_grant1    = i_req1_valid && (!i_req0_valid ||  r_prio);
    assign w_sel_op    = w_grant1 ? i_req1_op : i_req0_op;
    assign w_sel_a     = w_grant1 ? i_req1_a  : i_req0_a;
    assign w_sel_b     = w_grant1 ? i_req1_b  : i_req0_b;
    assign w_sel_undef = op_undefined(w_sel_op);
    assign w_rsp_ready = r_owner ? i_rsp1_ready : i_rsp0_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        w_accept     = 1'b0;
        w_rsp_done   = 1'b0;
        o_alu_op     = 4'b0000;
        o_alu_a      = '0;
        o_alu_b      = '0;

        case (r_state)
            IDLE: begin
                // Ready is gated by reset so it reads 0 while reset is held.
                if (!rst) begin
                    o_req0_ready = w_grant0;
                    o_req1_ready = w_grant1;
                    if (w_grant0 || w_grant1) begin
                        w_accept    = 1'b1;
                        w_state_nxt = w_sel_undef ? RESP : EXEC;
                    end
                end
            end
            EXEC: begin
                o_alu_op    = r_op;
                o_alu_a     = r_a;
                o_alu_b     = r_b;
                w_state_nxt = RESP;
            end
            RESP: begin
                if (w_rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio   <= 1'b0;
            r_owner  <= 1'b0;
            r_op     <= 4'b0000;
            r_a      <= '0;
            r_b      <= '0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= w_sel_op;
                r_a     <= w_sel_a;
                r_b     <= w_sel_b;
                r_owner <= w_grant1;
                r_err   <= w_sel_undef;
                // An undefined op skips EXEC, so its canned result is loaded here.
                if (w_sel_undef) begin
                    r_result <= '0;
                    r_zero   <= 1'b1;
                end
            end
            if (r_state == EXEC) begin
                r_result <= i_alu_out;
                r_zero   <= i_alu_zero;
            end
            if (w_rsp_done) begin
                r_prio <= ~r_owner;
            end
        end
    end

    always_comb begin
        o_rsp0_valid = 1'b0;
        o_rsp0_data  = '0;
        o_rsp0_zero  = 1'b0;
        o_rsp0_err   = 1'b0;
        o_rsp1_valid = 1'b0;
        o_rsp1_data  = '0;
        o_rsp1_zero  = 1'b0;
        o_rsp1_err   = 1'b0;
        if (r_state == RESP) begin
            if (r_owner) begin
                o_rsp1_valid = 1'b1;
                o_rsp1_data  = r_result;
                o_rsp1_zero  = r_zero;
                o_rsp1_err   = r_err;
            end else begin
                o_rsp0_valid = 1'b1;
                o_rsp0_data  = r_result;
                o_rsp0_zero  = r_zero;
                o_rsp0_err   = r_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 32-bit ALU attached to the ALU port.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = 0, req1_op = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 0, rsp1_ready = 0;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_out, imm;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_op(req0_op),
        .i_req0_a(req0_a), .i_req0_b(req0_b),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_op(req1_op),
        .i_req1_a(req1_a), .i_req1_b(req1_b),
        .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready), .o_rsp0_data(rsp0_data),
        .o_rsp0_zero(rsp0_zero), .o_rsp0_err(rsp0_err),
        .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready), .o_rsp1_data(rsp1_data),
        .o_rsp1_zero(rsp1_zero), .o_rsp1_err(rsp1_err),
        .o_alu_op(alu_op), .o_alu_a(alu_a), .o_alu_b(alu_b),
        .i_alu_out(alu_out), .i_alu_zero(alu_zero)
    );

    // Reference ALU; immediates come from b[11:0], sign-extended.
    always_comb begin
        imm = {{20{alu_b[11]}}, alu_b[11:0]};
        case (alu_op)
            4'b0000: alu_out = alu_a & alu_b;
            4'b0001: alu_out = alu_a | alu_b;
            4'b0010: alu_out = alu_a + alu_b;
            4'b0011: alu_out = alu_a ^ alu_b;
            4'b0100: alu_out = alu_a << alu_b[4:0];
            4'b0101: alu_out = alu_a >> alu_b[4:0];
            4'b0110: alu_out = alu_a - alu_b;
            4'b0111: alu_out = $signed(alu_a) >>> alu_b[4:0];
            4'b1000: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b1001: alu_out = {31'd0, alu_a < alu_b};
            4'b1100: alu_out = {31'd0, $signed(alu_a) < $signed(imm)};
            4'b1101: alu_out = {31'd0, alu_a < imm};
            default: alu_out = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1; req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    // Stimulus only: runs one transaction on a port and reports what came back.
    task automatic run_txn(input bit port, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] d, output logic z,
                           output logic e, output int lat, output logic [3:0] op_or,
                           output bit ok);
        ok = 0; lat = 0; op_or = 0; d = 0; z = 0; e = 0;
        @(negedge clk);
        rsp0_ready = 1; rsp1_ready = 1;
        if (port) begin
            req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        for (int k = 0; k < 20 && !(port ? req1_ready : req0_ready); k++) begin
            @(negedge clk); #1;
        end
        if (!(port ? req1_ready : req0_ready)) begin
            req0_valid = 0; req1_valid = 0;
            return;
        end
        op_or |= alu_op;
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #1; lat = 1;
        for (int k = 0; k < 20; k++) begin
            op_or |= alu_op;
            if (port ? rsp1_valid : rsp0_valid) begin
                d = port ? rsp1_data : rsp0_data;
                z = port ? rsp1_zero : rsp0_zero;
                e = port ? rsp1_err  : rsp0_err;
                ok = 1;
                break;
            end
            @(negedge clk); #1; lat++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; req0_valid = 1; req0_op = 4'b0010; req0_a = 1; req0_b = 2;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %b exp 0", req0_ready); end
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", {rsp0_valid, rsp1_valid}); end
        checks++; if ({rsp0_data, rsp1_data} !== 64'd0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", {rsp0_data, rsp1_data}); end
        checks++; if ({rsp0_zero, rsp1_zero, rsp0_err, rsp1_err} !== 4'b0000) begin errors++; $display("FAIL reset_zero_err got %b exp 0000", {rsp0_zero, rsp1_zero, rsp0_err, rsp1_err}); end
        checks++; if ({alu_op, alu_a, alu_b} !== 68'd0) begin errors++; $display("FAIL reset_alu got %h exp 0", {alu_op, alu_a, alu_b}); end
        req0_valid = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_single_add();
        do_reset();
        @(negedge clk);
        req0_valid = 1; req0_op = 4'b0010; req0_a = 5; req0_b = 7; rsp0_ready = 1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b exp 1", req0_ready); end
        checks++; if (alu_op !== 4'b0000) begin errors++; $display("FAIL add_alu_idle got %b exp 0000", alu_op); end
        @(negedge clk);
        req0_valid = 0;
        #1;
        checks++; if (alu_op !== 4'b0010 || alu_a !== 32'd5 || alu_b !== 32'd7) begin errors++; $display("FAIL add_alu_exec got %b %h %h exp 0010 5 7", alu_op, alu_a, alu_b); end
        checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL add_early_rsp got %b exp 0", rsp0_valid); end
        @(negedge clk); #1;
        checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd12 || rsp0_zero !== 1'b0) begin errors++; $display("FAIL add_rsp got v=%b d=%h z=%b exp 1 c 0", rsp0_valid, rsp0_data, rsp0_zero); end
        checks++; if (alu_op !== 4'b0000) begin errors++; $display("FAIL add_alu_resp got %b exp 0000", alu_op); end
        @(negedge clk); #1;
        checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_drop got %b exp 0", rsp0_valid); end
    endtask

    task automatic test_contention();
        int grants, rsps;
        do_reset();
        @(negedge clk);
        req0_valid = 1; req0_op = 4'b0110; req0_a = 10;  req0_b = 3;
        req1_valid = 1; req1_op = 4'b0011; req1_a = 32'hFF; req1_b = 32'h0F;
        rsp0_ready = 1; rsp1_ready = 1;
        grants = 0; rsps = 0;
        for (int cyc = 0; cyc < 100 && (grants < 8 || rsps < 8); cyc++) begin
            #1;
            if (req0_ready || req1_ready) begin
                checks++;
                if ((req0_ready && req1_ready) || req1_ready !== grants[0]) begin
                    errors++; $display("FAIL contention_grant%0d got r0=%b r1=%b exp r1=%b", grants, req0_ready, req1_ready, grants[0]);
                end
                grants++;
            end
            if (rsp0_valid) begin
                checks++; if (rsp0_data !== 32'd7 || rsp1_valid) begin errors++; $display("FAIL contention_rsp0 got %h v1=%b exp 7 v1=0", rsp0_data, rsp1_valid); end
                rsps++;
            end
            if (rsp1_valid) begin
                checks++; if (rsp1_data !== 32'hF0) begin errors++; $display("FAIL contention_rsp1 got %h exp f0", rsp1_data); end
                rsps++;
            end
            @(negedge clk);
            if (grants >= 8) begin req0_valid = 0; req1_valid = 0; end
        end
        checks++; if (grants != 8 || rsps != 8) begin errors++; $display("FAIL contention_count got grants=%0d rsps=%0d exp 8 8", grants, rsps); end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_compares();
        logic [31:0] d; logic z, e; int lat; logic [3:0] ops; bit ok;
        do_reset();
        run_txn(0, 4'b1000, 32'hFFFF_FFFF, 32'd1, d, z, e, lat, ops, ok);
        checks++; if (!ok || d !== 32'd1 || lat != 2) begin errors++; $display("FAIL slt got ok=%b d=%h lat=%0d exp 1 1 2", ok, d, lat); end
        run_txn(0, 4'b1001, 32'hFFFF_FFFF, 32'd1, d, z, e, lat, ops, ok);
        checks++; if (!ok || d !== 32'd0 || z !== 1'b1) begin errors++; $display("FAIL sltu got ok=%b d=%h z=%b exp 1 0 1", ok, d, z); end
        run_txn(0, 4'b1100, 32'd5, 32'h0000_0FFF, d, z, e, lat, ops, ok);
        checks++; if (!ok || d !== 32'd0) begin errors++; $display("FAIL slti got ok=%b d=%h exp 1 0", ok, d); end
        run_txn(0, 4'b1101, 32'd5, 32'h0000_0FFF, d, z, e, lat, ops, ok);
        checks++; if (!ok || d !== 32'd1) begin errors++; $display("FAIL sltiu got ok=%b d=%h exp 1 1", ok, d); end
        run_txn(0, 4'b0111, 32'h8000_0000, 32'd4, d, z, e, lat, ops, ok);
        checks++; if (!ok || d !== 32'hF800_0000 || z !== 1'b0) begin errors++; $display("FAIL sra got ok=%b d=%h z=%b exp 1 f8000000 0", ok, d, z); end
        run_txn(1, 4'b0101, 32'h8000_0000, 32'd4, d, z, e, lat, ops, ok);
        checks++; if (!ok || d !== 32'h0800_0000) begin errors++; $display("FAIL srl got ok=%b d=%h exp 1 08000000", ok, d); end
        run_txn(1, 4'b0110, 32'd9, 32'd9, d, z, e, lat, ops, ok);
        checks++; if (!ok || d !== 32'd0 || z !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL sub_zero got ok=%b d=%h z=%b e=%b exp 1 0 1 0", ok, d, z, e); end
    endtask

    task automatic test_undefined();
        logic [31:0] d; logic z, e; int lat; logic [3:0] ops; bit ok;
        do_reset();
        run_txn(1, 4'b1010, 32'd123, 32'd456, d, z, e, lat, ops, ok);
        checks++; if (!ok || lat != 1) begin errors++; $display("FAIL undef_latency got ok=%b lat=%0d exp 1 1", ok, lat); end
        checks++; if (d !== 32'd0 || z !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL undef_rsp got d=%h z=%b e=%b exp 0 1 1", d, z, e); end
        checks++; if (ops !== 4'b0000) begin errors++; $display("FAIL undef_alu_op got %b exp 0000", ops); end
        run_txn(0, 4'b1111, 32'd1, 32'd1, d, z, e, lat, ops, ok);
        checks++; if (!ok || lat != 1 || e !== 1'b1 || ops !== 4'b0000) begin errors++; $display("FAIL undef_1111 got ok=%b lat=%0d e=%b ops=%b exp 1 1 1 0000", ok, lat, e, ops); end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        req0_valid = 1; req0_op = 4'b0010; req0_a = 5; req0_b = 7;
        req1_valid = 1; req1_op = 4'b0001; req1_a = 3; req1_b = 4;
        rsp0_ready = 0; rsp1_ready = 1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_grant got r0=%b r1=%b exp 1 0", req0_ready, req1_ready); end
        @(negedge clk);
        req0_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd12 || rsp0_zero !== 1'b0 || rsp0_err !== 1'b0 || req1_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got v=%b d=%h z=%b e=%b r1=%b exp 1 c 0 0 0", i, rsp0_valid, rsp0_data, rsp0_zero, rsp0_err, req1_ready);
            end
        end
        rsp0_ready = 1;
        @(negedge clk); #1;
        checks++; if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL bp_next_accept got r1=%b v0=%b exp 1 0", req1_ready, rsp0_valid); end
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk); #1;
        checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 32'd7) begin errors++; $display("FAIL bp_rsp1 got v=%b d=%h exp 1 7", rsp1_valid, rsp1_data); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d; logic z, e; int lat; logic [3:0] ops; bit ok;
        do_reset();
        run_txn(0, 4'b0010, 32'd1, 32'd1, d, z, e, lat, ops, ok);
        @(negedge clk);
        req0_valid = 1; req0_op = 4'b0010; req0_a = 2; req0_b = 3;
        @(negedge clk);
        req0_valid = 0;
        #1;
        checks++; if (alu_op !== 4'b0010) begin errors++; $display("FAIL midrst_exec got %b exp 0010", alu_op); end
        #2;
        rst = 1; req1_valid = 1;
        #1;
        checks++;
        if (alu_op !== 4'b0000 || alu_a !== 32'd0 || alu_b !== 32'd0 || req0_ready || req1_ready || rsp0_valid || rsp1_valid) begin
            errors++; $display("FAIL midrst_outputs got op=%b a=%h b=%h r=%b%b v=%b%b exp all 0", alu_op, alu_a, alu_b, req0_ready, req1_ready, rsp0_valid, rsp1_valid);
        end
        req1_valid = 0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (rsp0_valid || rsp1_valid) begin errors++; $display("FAIL midrst_no_rsp%0d got %b%b exp 00", i, rsp0_valid, rsp1_valid); end
            @(negedge clk);
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL midrst_prio got r0=%b r1=%b exp 1 0", req0_ready, req1_ready); end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_contention();
        test_compares();
        test_undefined();
        test_backpressure();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single ALU instance between two requesters (e.g. the integer-pipe execute stage and a multi-cycle helper unit) using valid/ready handshakes and round-robin arbitration. It sits between the requesters and the ALU: the block captures one operation, drives the ALU from registered operands for one cycle, registers the result, and returns it on the matching response channel. It also screens ALU opcodes and flags undefined encodings instead of issuing them.

## Interface
- WIDTH, 32: operand/result width; the ALU is 32-bit, so only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_op / req1_op  in  4  ALU operation code.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands; b carries the immediate for SLTI/SLTIU in bits [11:0].
- rsp0_valid / rsp1_valid  out  1  result available.
- rsp0_ready / rsp1_ready  in  1  requester takes result.
- rsp0_data / rsp1_data  out  WIDTH  result.
- rsp0_zero / rsp1_zero  out  1  result == 0.
- rsp0_err / rsp1_err  out  1  opcode was undefined.
- alu_op  out  4  to ALU.
- alu_a, alu_b  out  WIDTH  to ALU.
- alu_out  in  WIDTH  from ALU.
- alu_zero  in  1  from ALU.

## Operation
- Legal opcodes are AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001, SLTI 1100 and SLTIU 1101. The opcodes 1010, 1011, 1110 and 1111 are undefined.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - If no req_valid is asserted, stay in IDLE.
  - Otherwise grant exactly one requester. If only one is valid, grant it. If both are valid, grant the one selected by the priority pointer `prio` (reset 0 = req0).
  - reqN_ready = (state==IDLE) && grantN, combinationally, so at most one ready is high per cycle.
  - On the handshake, latch op/a/b, latch owner=N, and set err_q = (op undefined).
  - Next state: EXEC for a legal op; RESP directly for an undefined op.
- **EXEC**
  - Drive alu_op/alu_a/alu_b from the latched registers.
  - At the clock edge, capture alu_out into the result register and alu_zero into the zero register.
  - Next state is RESP.
- **RESP**
  - rsp{owner}_valid=1 and rsp{owner}_data/zero/err come from the registers. The other response channel stays at valid=0.
  - For an undefined op, data=0, zero=1 and err=1, and the ALU is never driven with that op.
  - Hold until rsp{owner}_ready. On the handshake: prio = ~owner, and next state is IDLE.
- ALU drive outside EXEC: alu_op=0000, alu_a=0, alu_b=0. This keeps ALU inputs quiet.
- Requests are not accepted in EXEC or RESP: both req_ready are 0. There is a single outstanding transaction.
- Requester obligation: payload is stable while valid && !ready. Arbitration is re-evaluated every IDLE cycle, so a valid that drops before ready is simply not granted.

## Timing
- Reset (asynchronous, takes effect immediately) and its values:
  - state=IDLE and prio=0.
  - All req_ready=0 and all rsp_valid=0.
  - All rsp_data=0, rsp_zero=0, rsp_err=0.
  - alu_op/a/b=0.
- Reset mid-transaction discards the transaction; no response is produced.
- Legal-op latency: accept at edge T (IDLE), ALU result captured at T+1 (EXEC), rsp_valid high in the cycle after T+1. That is 2 cycles from accept to response.
- Undefined-op latency: 1 cycle from accept to response.
- Minimum request-to-request spacing is 3 cycles for a legal op with rsp_ready held high. A response handshake at edge E allows a new accept at edge E+1.
- Fairness under continuous contention from both requesters: grants strictly alternate 0,1,0,1,…
- With only one requester active, it is served back-to-back. Its completions still update prio.
- rsp outputs are registered and never change while rsp_valid=1 and rsp_ready=0.

## Test plan
- Single request, legal op: reset, then req0 ADD a=5 b=7 with rsp0_ready=1. Required: req0_ready in the first cycle; rsp0_valid 2 cycles after accept with data=12 and zero=0; alu_op=0010 only during EXEC.
- Contention fairness: req0 and req1 both hold valid with SUB 10-3 and XOR FF^0F for 4 transactions each. Required grant order 0,1,0,1,…; rsp0_data=7 and rsp1_data=F0. Req1 is never starved.
- Signed vs unsigned compares and shifts:
  - SLT 0xFFFFFFFF<1 gives 1.
  - SLTU 0xFFFFFFFF<1 gives 0.
  - SLTI rd1=5, b=0x00000FFF gives 0.
  - SRA 0x80000000 by 4 gives 0xF8000000, with zero=0.
  - SUB 9-9 gives data 0 and zero=1.
- Undefined op: req1 op=1010. Required: rsp1 arrives 1 cycle after accept with data=0, zero=1, err=1, and alu_op stays 0000 throughout.
- Response backpressure: hold rsp0_ready=0 for 5 cycles while req1_valid=1. Required: rsp0 outputs stay stable, req1_ready=0 throughout, and req1 is accepted the cycle after the rsp0 handshake.
- Reset mid-op: assert rst during EXEC. Required: all outputs go to their reset values immediately, no response afterwards, and prio=0, so req0 wins the next contention.
